// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity types and line levels.
// Imported by the transmitter, the receiver and the verification scoreboard.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial line of the UART transmitter.
// master drives a byte request, slave is the transmitter itself.
interface uart_tx_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int SCALER_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]   P_DATA;
  logic                    Data_Valid;
  logic [SCALER_WIDTH-1:0] Prescale;
  logic                    PAR_EN;
  logic                    PAR_TYP;
  logic                    TX_OUT;
  logic                    busy;

  modport master (
    output P_DATA, Data_Valid, Prescale, PAR_EN, PAR_TYP,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, Prescale, PAR_EN, PAR_TYP,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_parity.sv
// Combinational parity generator: even parity when PAR_TYP selects PAR_EVEN, odd otherwise.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);
  assign o_parity = (^i_data) ^ (i_par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit, Prescale clocks per bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int scaler_width    = 5,
  parameter int bit_count_width = 3
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);

  localparam logic [bit_count_width-1:0] LAST_BIT = bit_count_width'(DATA_WIDTH - 1);
  localparam logic [bit_count_width-1:0] BIT_ONE  = {{(bit_count_width-1){1'b0}}, 1'b1};
  localparam logic [scaler_width-1:0]    CNT_ZERO = {scaler_width{1'b0}};
  localparam logic [scaler_width-1:0]    CNT_ONE  = {{(scaler_width-1){1'b0}}, 1'b1};

  uart_tx_state_e             r_state;
  logic [scaler_width-1:0]    r_cnt;
  logic [scaler_width-1:0]    r_pm1;
  logic [bit_count_width-1:0] r_bit_cnt;
  logic [DATA_WIDTH-1:0]      r_shadow;
  logic                       r_tx_out;

  logic                       w_last_tick;
  logic                       w_busy;
  logic                       w_accept;
  logic [scaler_width-1:0]    w_pm1_in;
  logic [bit_count_width-1:0] w_bit_nxt;

  // Prescale of 0 behaves as 1, so the stored terminal count saturates at 0.
  assign w_pm1_in    = (bus.Prescale == CNT_ZERO) ? CNT_ZERO : (bus.Prescale - CNT_ONE);
  assign w_last_tick = (r_cnt == r_pm1);
  assign w_busy      = (r_state != IDLE) && !((r_state == STOP) && w_last_tick);
  assign w_accept    = bus.Data_Valid && !w_busy;
  assign w_bit_nxt   = r_bit_cnt + BIT_ONE;

  assign bus.TX_OUT = r_tx_out;
  assign bus.busy   = w_busy;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_bit;
  logic w_par_bit;

  uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .i_data    (bus.P_DATA),
    .i_par_typ (bus.PAR_TYP),
    .o_parity  (w_par_bit)
  );

  // Parity configuration is frozen with the frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_par_en  <= bus.PAR_EN;
      r_par_bit <= w_par_bit;
    end else begin
      r_par_en  <= r_par_en;
      r_par_bit <= r_par_bit;
    end
  end
`else
  logic w_unused_par;
  assign w_unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  // Frame FSM; TX_OUT is loaded with the level of the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= CNT_ZERO;
      r_pm1     <= CNT_ZERO;
      r_bit_cnt <= {bit_count_width{1'b0}};
      r_shadow  <= {DATA_WIDTH{1'b0}};
      r_tx_out  <= STOP_BIT;
    end else if (w_accept) begin
      r_state   <= START;
      r_cnt     <= CNT_ZERO;
      r_pm1     <= w_pm1_in;
      r_bit_cnt <= {bit_count_width{1'b0}};
      r_shadow  <= bus.P_DATA;
      r_tx_out  <= START_BIT;
    end else begin
      if (r_state == IDLE || w_last_tick) begin
        r_cnt <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      case (r_state)
        IDLE: begin
          r_tx_out <= STOP_BIT;
        end
        START: begin
          if (w_last_tick) begin
            r_state   <= DATA;
            r_bit_cnt <= {bit_count_width{1'b0}};
            r_tx_out  <= r_shadow[0];
          end
        end
        DATA: begin
          if (w_last_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              if (r_par_en) begin
                r_state  <= PARITY;
                r_tx_out <= r_par_bit;
              end else begin
                r_state  <= STOP;
                r_tx_out <= STOP_BIT;
              end
`else
              r_state  <= STOP;
              r_tx_out <= STOP_BIT;
`endif
            end else begin
              r_bit_cnt <= w_bit_nxt;
              r_tx_out  <= r_shadow[w_bit_nxt];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_last_tick) begin
            r_state  <= STOP;
            r_tx_out <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (w_last_tick) begin
            r_state  <= IDLE;
            r_tx_out <= STOP_BIT;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tx_out <= STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted requests push expected frames, a line monitor pops and checks them.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int SW = 5;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef struct {
    int          acc_edge;
    int          p;
    int          nbits;
    logic [15:0] bits;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_tx_if #(.DATA_WIDTH(DW), .SCALER_WIDTH(SW)) bus ();

  uart_tx #(.DATA_WIDTH(DW), .scaler_width(SW), .bit_count_width(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  exp_t q[$];
  exp_t cur;
  bit   mon_active = 1'b0;
  int   mon_idx = 0;
  int   model_free = 0;
  int   n_accept = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic cur_exp_par = 1'b0;

  task automatic report(string name, int act, int req);
    n_err++;
    if (n_err <= 25)
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
  endtask

  task automatic check_bit(string name, logic act, logic req);
    n_vec++;
    if (act !== req) report(name, int'(act), int'(req));
  endtask

  task automatic check_int(string name, int act, int req);
    n_vec++;
    if (act != req) report(name, act, req);
  endtask

  // One clock of stimulus; mirrors acceptance so the expected frame is queued.
  task automatic tick();
    int   e;
    int   n;
    exp_t x;
    e = cyc + 1;
    if (!RST && bus.Data_Valid && e >= model_free) begin
      x.bits     = '0;
      x.bits[0]  = START_BIT;
      for (int i = 0; i < DW; i++) x.bits[i+1] = bus.P_DATA[i];
      n = DW + 1;
      if (PAR_BUILD && bus.PAR_EN) begin
        x.bits[n] = cur_exp_par;
        n++;
      end
      x.bits[n]  = STOP_BIT;
      n++;
      x.acc_edge = e;
      x.p        = (bus.Prescale == 5'd0) ? 1 : int'(bus.Prescale);
      x.nbits    = n;
      q.push_back(x);
      model_free = e + n * x.p;
      n_accept++;
    end
    if (RST) model_free = e + 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(logic [7:0] d, logic [4:0] ps, logic pe, logic pt, logic ep);
    bus.P_DATA     = d;
    bus.Prescale   = ps;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    cur_exp_par    = ep;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = ~d;
    bus.Prescale   = 5'd3;
    bus.PAR_EN     = ~pe;
    bus.PAR_TYP    = ~pt;
  endtask

  task automatic wait_done(int budget);
    int k;
    k = 0;
    while ((q.size() > 0 || mon_active) && k < budget) begin
      tick();
      k++;
    end
    if (q.size() > 0 || mon_active) begin
      n_vec++;
      report("frame_timeout", k, budget);
    end
  endtask

  // Line monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_active = 1'b0;
        q.delete();
      end else begin
        if (!mon_active) begin
          if (q.size() > 0 && cyc > q[0].acc_edge) begin
            n_vec++;
            report("missing_start", cyc, q[0].acc_edge);
            void'(q.pop_front());
          end
          if (bus.TX_OUT === 1'b0) begin
            if (q.size() > 0) begin
              cur = q.pop_front();
              check_int("start_edge", cyc, cur.acc_edge);
              mon_active = 1'b1;
              mon_idx    = 0;
            end else begin
              n_vec++;
              report("unexpected_start", 0, 1);
            end
          end else begin
            check_bit("idle_line", bus.TX_OUT, 1'b1);
            check_bit("idle_busy", bus.busy, 1'b0);
          end
        end
        if (mon_active) begin
          check_bit("tx_bit", bus.TX_OUT, cur.bits[mon_idx / cur.p]);
          check_bit("busy", bus.busy, (mon_idx != cur.nbits * cur.p - 1));
          mon_idx++;
          if (mon_idx == cur.nbits * cur.p) mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    int base;
    int k;
    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.Prescale   = 5'd16;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    RST            = 1'b1;
    repeat (3) tick();
    check_bit("reset_tx", bus.TX_OUT, 1'b1);
    check_bit("reset_busy", bus.busy, 1'b0);
    RST = 1'b0;
    repeat (50) tick();

    // A5 = 1010_0101, four ones: even parity 0, odd parity 1
    send(8'hA5, 5'd16, 1'b1, 1'b0, 1'b0);
    wait_done(400);
    send(8'hA5, 5'd16, 1'b1, 1'b1, 1'b1);
    wait_done(400);
    send(8'hA5, 5'd16, 1'b0, 1'b0, 1'b0);
    wait_done(400);

    // Data_Valid held high: 00 then FF, gapless
    base           = n_accept;
    bus.Prescale   = 5'd8;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b1;
    tick();
    bus.P_DATA = 8'hFF;
    k = 0;
    while (n_accept < base + 2 && k < 200) begin
      tick();
      k++;
    end
    bus.Data_Valid = 1'b0;
    check_int("held_frames", n_accept - base, 2);
    wait_done(200);

    // request pulse mid-frame must be ignored
    send(8'h5A, 5'd8, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    bus.P_DATA     = 8'hC3;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
    wait_done(200);

    // reset at cycle 60 of a frame, then 3C (four ones, even parity 0)
    send(8'hE7, 5'd16, 1'b1, 1'b0, 1'b0);
    repeat (59) tick();
    RST = 1'b1;
    tick();
    check_bit("midrst_tx", bus.TX_OUT, 1'b1);
    check_bit("midrst_busy", bus.busy, 1'b0);
    RST = 1'b0;
    send(8'h3C, 5'd16, 1'b1, 1'b0, 1'b0);
    wait_done(400);

    // Prescale 0 acts as 1; 81 has two ones, even parity 0
    send(8'h81, 5'd0, 1'b0, 1'b0, 1'b0);
    wait_done(40);
    send(8'h81, 5'd0, 1'b1, 1'b0, 1'b0);
    wait_done(40);
    send(8'h81, 5'd1, 1'b0, 1'b1, 1'b1);
    wait_done(40);

    repeat (10) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got %0d cycles, required fewer", cyc);
    $fatal(1);
  end

endmodule
